// File: rtl/fetch_pkg.sv
// Shared widths, reset PC and FSM state type for the fetch stage.
package fetch_pkg;

  localparam int unsigned PC_W   = 16;
  localparam int unsigned INSN_W = 16;
  localparam logic [15:0] START_PC = 16'd6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_out_reg.sv
// Output register of the fetch stage with its valid/ready handshake.
module fetch_out_reg #(
  parameter int unsigned PC_W   = 16,
  parameter int unsigned INSN_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_capture,
  input  logic              i_flush,
  input  logic              i_ready,
  input  logic [INSN_W-1:0] i_instruction,
  input  logic [PC_W-1:0]   i_pc,
  output logic              o_valid,
  output logic              o_accept,
  output logic [INSN_W-1:0] o_instruction,
  output logic [PC_W-1:0]   o_pc
);

  logic              r_valid;
  logic [INSN_W-1:0] r_instruction;
  logic [PC_W-1:0]   r_pc;

  // Flush wins over capture; an accepted entry drains when nothing replaces it.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_valid       <= 1'b0;
      r_instruction <= '0;
      r_pc          <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_capture) begin
      r_valid       <= 1'b1;
      r_instruction <= i_instruction;
      r_pc          <= i_pc;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid       = r_valid;
  assign o_accept      = r_valid && i_ready;
  assign o_instruction = r_instruction;
  assign o_pc          = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: IDLE/RUN FSM, program counter, accepted-transfer counter.
module fetch_stage #(
  parameter int unsigned       PC_W     = fetch_pkg::PC_W,
  parameter int unsigned       INSN_W   = fetch_pkg::INSN_W,
  parameter logic [PC_W-1:0]   START_PC = PC_W'(fetch_pkg::START_PC)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   pc,
  input  logic [INSN_W-1:0] raw_instruction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INSN_W-1:0] out_instruction,
  output logic [PC_W-1:0]   out_pc,
  output logic              running,
  output logic [15:0]       fetch_count
);

  import fetch_pkg::*;

  fetch_state_t    r_state;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_count;
  logic            w_out_valid;
  logic            w_accept;
  logic            w_capture;

  assign w_capture = (r_state == RUN) && !stop && !redirect_valid && (!w_out_valid || out_ready);

  // FSM: start only matters in IDLE, stop only in RUN; redirect never changes state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) r_state <= RUN;
        RUN:     if (stop)  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Program counter: redirect first, else advance (wrapping) on each capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc <= START_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (w_capture) begin
      r_pc <= r_pc + PC_W'(1);
    end
  end

  // Saturating count of accepted transfers, including those flushed by a redirect.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (w_accept && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  fetch_out_reg #(
    .PC_W  (PC_W),
    .INSN_W(INSN_W)
  ) u_out_reg (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_capture    (w_capture),
    .i_flush      (redirect_valid),
    .i_ready      (out_ready),
    .i_instruction(raw_instruction),
    .i_pc         (r_pc),
    .o_valid      (w_out_valid),
    .o_accept     (w_accept),
    .o_instruction(out_instruction),
    .o_pc         (out_pc)
  );

  assign pc          = r_pc;
  assign out_valid   = w_out_valid;
  assign running     = (r_state == RUN);
  assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] pc;
  logic [15:0] raw_instruction;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instruction;
  logic [15:0] out_pc;
  logic        running;
  logic [15:0] fetch_count;

  int n_cmp;
  int n_fail;

  fetch_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .stop           (stop),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .raw_instruction(raw_instruction),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instruction(out_instruction),
    .out_pc         (out_pc),
    .running        (running),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction cache model: three fixed words, else the inverted address.
  function automatic logic [15:0] cache(input logic [15:0] a);
    case (a)
      16'd6:   return 16'hd000;
      16'd7:   return 16'h4080;
      16'd8:   return 16'h2000;
      default: return ~a;
    endcase
  endfunction

  always_comb raw_instruction = cache(pc);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 16'h0; out_ready = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %h want 0", out_valid); end
    n_cmp++; if (pc !== 16'd6) begin n_fail++; $display("FAIL reset_pc got %h want 0006", pc); end
    n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %h want 0", running); end
    n_cmp++; if (fetch_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %h want 0", fetch_count); end
    n_cmp++; if ({out_instruction, out_pc} !== 32'h0) begin n_fail++; $display("FAIL reset_outregs got %h/%h want 0/0", out_instruction, out_pc); end
  endtask

  task automatic test_basic();
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if ({running, out_valid} !== 2'b10) begin n_fail++; $display("FAIL basic_cycle1 got run=%b valid=%b want run=1 valid=0", running, out_valid); end
    tick();
    n_cmp++; if ({out_valid, out_pc, out_instruction} !== {1'b1, 16'd6, 16'hd000}) begin n_fail++; $display("FAIL basic_first got v=%b pc=%h insn=%h want v=1 pc=0006 insn=d000", out_valid, out_pc, out_instruction); end
    tick();
    n_cmp++; if ({out_valid, out_pc, out_instruction} !== {1'b1, 16'd7, 16'h4080}) begin n_fail++; $display("FAIL basic_second got v=%b pc=%h insn=%h want v=1 pc=0007 insn=4080", out_valid, out_pc, out_instruction); end
    tick();
    n_cmp++; if ({out_valid, out_pc, out_instruction} !== {1'b1, 16'd8, 16'h2000}) begin n_fail++; $display("FAIL basic_third got v=%b pc=%h insn=%h want v=1 pc=0008 insn=2000", out_valid, out_pc, out_instruction); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++; if (fetch_count !== 16'd3) begin n_fail++; $display("FAIL basic_count got %0d want 3", fetch_count); end
    n_cmp++; if ({running, out_valid, pc} !== {2'b00, 16'd9}) begin n_fail++; $display("FAIL basic_stopped got run=%b v=%b pc=%h want 0 0 0009", running, out_valid, pc); end
  endtask

  task automatic test_stall();
    redirect_valid = 1'b1; redirect_pc = 16'd6;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if ({running, pc} !== {1'b0, 16'd6}) begin n_fail++; $display("FAIL idle_redirect got run=%b pc=%h want 0 0006", running, pc); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    n_cmp++; if ({out_pc, fetch_count} !== {16'd7, 16'd4}) begin n_fail++; $display("FAIL stall_setup got pc=%h cnt=%0d want 0007 4", out_pc, fetch_count); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({out_valid, out_pc, out_instruction, pc} !== {1'b1, 16'd7, 16'h4080, 16'd8}) begin
        n_fail++;
        $display("FAIL stall_hold%0d got v=%b opc=%h insn=%h pc=%h want 1 0007 4080 0008", i, out_valid, out_pc, out_instruction, pc);
      end
    end
    out_ready = 1'b1;
    tick();
    n_cmp++; if ({out_valid, out_pc, out_instruction, fetch_count} !== {1'b1, 16'd8, 16'h2000, 16'd5}) begin n_fail++; $display("FAIL stall_release got v=%b pc=%h insn=%h cnt=%0d want 1 0008 2000 5", out_valid, out_pc, out_instruction, fetch_count); end
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if ({out_pc, out_instruction, fetch_count} !== {16'd12, ~16'd12, 16'd9}) begin n_fail++; $display("FAIL redir_setup got pc=%h insn=%h cnt=%0d want 000c fff3 9", out_pc, out_instruction, fetch_count); end
    redirect_valid = 1'b1; redirect_pc = 16'd6;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if ({out_valid, running, pc, fetch_count} !== {2'b01, 16'd6, 16'd10}) begin n_fail++; $display("FAIL redir_flush got v=%b run=%b pc=%h cnt=%0d want 0 1 0006 10", out_valid, running, pc, fetch_count); end
    tick();
    n_cmp++; if ({out_valid, out_pc, out_instruction} !== {1'b1, 16'd6, 16'hd000}) begin n_fail++; $display("FAIL redir_target got v=%b pc=%h insn=%h want 1 0006 d000", out_valid, out_pc, out_instruction); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_cmp++; if ({out_valid, out_pc, out_instruction} !== {1'b1, 16'hFFFE, 16'h0001}) begin n_fail++; $display("FAIL wrap_fffe got v=%b pc=%h insn=%h want 1 fffe 0001", out_valid, out_pc, out_instruction); end
    tick();
    n_cmp++; if ({out_valid, out_pc, pc} !== {1'b1, 16'hFFFF, 16'h0000}) begin n_fail++; $display("FAIL wrap_ffff got v=%b opc=%h pc=%h want 1 ffff 0000", out_valid, out_pc, pc); end
    tick();
    n_cmp++; if ({out_valid, out_pc, out_instruction, pc} !== {1'b1, 16'h0000, 16'hFFFF, 16'h0001}) begin n_fail++; $display("FAIL wrap_0000 got v=%b opc=%h insn=%h pc=%h want 1 0000 ffff 0001", out_valid, out_pc, out_instruction, pc); end
  endtask

  task automatic test_stop_pending();
    out_ready = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++; if ({running, out_valid, out_pc, pc} !== {2'b01, 16'h0000, 16'h0001}) begin n_fail++; $display("FAIL stop_held got run=%b v=%b opc=%h pc=%h want 0 1 0000 0001", running, out_valid, out_pc, pc); end
    tick();
    n_cmp++; if ({out_valid, out_pc} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL stop_held2 got v=%b opc=%h want 1 0000", out_valid, out_pc); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if ({out_valid, fetch_count} !== {1'b0, 16'd14}) begin n_fail++; $display("FAIL stop_drain got v=%b cnt=%0d want 0 14", out_valid, fetch_count); end
    tick();
    n_cmp++; if ({out_valid, pc, running} !== {1'b0, 16'h0001, 1'b0}) begin n_fail++; $display("FAIL stop_nocapture got v=%b pc=%h run=%b want 0 0001 0", out_valid, pc, running); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++; if ({out_valid, out_pc} !== {1'b1, 16'h0001}) begin n_fail++; $display("FAIL rstmid_setup got v=%b opc=%h want 1 0001", out_valid, out_pc); end
    reset_n = 1'b0; start = 1'b1;
    tick();
    reset_n = 1'b1; start = 1'b0;
    n_cmp++; if ({out_valid, pc, fetch_count, running, out_pc} !== {1'b0, 16'd6, 16'd0, 1'b0, 16'd0}) begin n_fail++; $display("FAIL rstmid got v=%b pc=%h cnt=%0d run=%b opc=%h want 0 0006 0 0 0000", out_valid, pc, fetch_count, running, out_pc); end
  endtask

  task automatic test_stop_redirect();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    stop = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'd20;
    tick();
    stop = 1'b0; redirect_valid = 1'b0;
    n_cmp++; if ({running, out_valid, pc, fetch_count} !== {2'b00, 16'd20, 16'd1}) begin n_fail++; $display("FAIL stop_redir got run=%b v=%b pc=%h cnt=%0d want 0 0 0014 1", running, out_valid, pc, fetch_count); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_wrap();
    test_stop_pending();
    test_reset_mid();
    test_stop_redirect();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter START_PC, default 16'd6, PC loaded at reset.
REQ-002 SHALL have parameter PC_W, default 16, program-counter width.
REQ-003 SHALL have parameter INSN_W, default 16, raw instruction width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin fetching.
REQ-007 SHALL have port stop  input  1  single-cycle request to cease fetching.
REQ-008 SHALL have port redirect_valid  input  1  jump or loop-back request.
REQ-009 SHALL have port redirect_pc  input  PC_W  target PC for the redirect.
REQ-010 SHALL have port pc  output  PC_W  address driven to the combinational instruction cache.
REQ-011 SHALL have port raw_instruction  input  INSN_W  cache data for pc, valid in the same cycle.
REQ-012 SHALL have port out_valid  output  1  the output register holds an instruction.
REQ-013 SHALL have port out_ready  input  1  the downstream decoder accepts the instruction.
REQ-014 SHALL have port out_instruction  output  INSN_W  registered instruction.
REQ-015 SHALL have port out_pc  output  PC_W  PC of out_instruction.
REQ-016 SHALL have port running  output  1  the FSM is in RUN.
REQ-017 SHALL have port fetch_count  output  16  count of accepted transfers.

Function
REQ-018 SHALL implement a two-state FSM, IDLE and RUN: IDLE->RUN on start; RUN->IDLE on stop; otherwise hold.
- start is ignored in RUN.
- stop is ignored in IDLE.
REQ-019 SHALL define capture = RUN && !stop && !redirect_valid && (!out_valid || out_ready).
REQ-020 On capture, at the next edge, SHALL load:
- out_instruction <= raw_instruction
- out_pc <= pc
- out_valid <= 1
- pc <= pc+1
REQ-021 SHALL wrap pc modulo 2^PC_W: 16'hFFFF+1 = 16'h0000, with no flag.
REQ-022 When out_valid && out_ready && !capture, SHALL clear out_valid at the next edge.
REQ-023 While out_valid && !out_ready, SHALL hold out_instruction, out_pc, out_valid and pc stable.
REQ-024 On redirect_valid, in any state, SHALL load pc <= redirect_pc and out_valid <= 0 at the next edge (flush).
- Redirect has priority over capture.
- The FSM state is unaffected by redirect.
REQ-025 When redirect_valid coincides with out_valid && out_ready, SHALL count that transfer as accepted; the flush applies afterwards.
REQ-026 When stop and redirect_valid coincide, SHALL apply both: state -> IDLE, pc <= redirect_pc, out_valid <= 0.
REQ-027 On stop without redirect, SHALL keep any pending out_valid until it is accepted; no new capture occurs in IDLE.
REQ-028 SHALL increment fetch_count on each cycle with out_valid && out_ready, saturating at 16'hFFFF.
REQ-029 Fetch latency: with start high in cycle 0 and out_ready=1, SHALL assert out_valid in cycle 2 with out_pc=START_PC; afterwards one instruction per cycle.
REQ-030 SHALL drive pc combinationally from the PC register only, with no path from inputs.

Reset
REQ-031 While reset_n=0 at an edge, SHALL set state=IDLE, pc=START_PC, out_valid=0, out_instruction=0, out_pc=0, fetch_count=0.
REQ-032 Reset mid-operation SHALL discard any pending output; reset has priority over all other inputs.
REQ-033 running SHALL read 0 in the cycle after reset.

Structure
REQ-034 SHALL place PC_W, INSN_W, START_PC and the fetch_state_t enum (IDLE, RUN) in the shared package fetch_pkg.
REQ-035 SHALL isolate the output register and handshake in one sub-module, fetch_out_reg; the FSM, PC and counter live in fetch_stage.

Verification
REQ-036 Reset, then start pulse, out_ready=1, cache mapping 6->d000, 7->4080, 8->2000 -> out_valid in cycle 2 with (6,d000), then (7,4080), then (8,2000); fetch_count=3.
REQ-037 out_ready=0 for 3 cycles while out_valid=1 at out_pc=7 -> outputs and pc=8 held; release -> (8,2000) next cycle, no instruction lost or duplicated.
REQ-038 Redirect to pc 6 while out_pc=12 is valid and out_ready=1 -> 12 counted, out_valid=0 next cycle, then (6,d000) on the following cycle.
REQ-039 redirect_pc=16'hFFFE in RUN -> out_pc sequence FFFE, FFFF, 0000.
REQ-040 stop while out_valid=1 and out_ready=0 -> running=0 next cycle, out_valid held until accepted, no further captures.
REQ-041 reset_n=0 for one cycle mid-RUN with out_valid=1 -> next cycle out_valid=0, pc=6, fetch_count=0, running=0.
